// File: rtl/pc_seq_if.sv
// Request/response bundle between decode/execute control and the PC sequencer.
// The master issues retire/redirect requests and sees the fetch PC; the slave is the sequencer.
interface pc_seq_if #(
    parameter int XLEN = 32
);
    logic            advance;
    logic            inc_half;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            trap;
    logic [XLEN-1:0] trap_vector;
    logic            mret;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [XLEN-1:0] epc;
    logic            misaligned;

    modport master (
        output advance, inc_half, jump, jump_target, trap, trap_vector, mret,
        input  pc, pc_valid, epc, misaligned
    );

    modport slave (
        input  advance, inc_half, jump, jump_target, trap, trap_vector, mret,
        output pc, pc_valid, epc, misaligned
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the architectural PC, picks the next PC from
// increment / jump / trap vector / epc, and turns misaligned jumps into trap entry.
//
// state  | meaning
// BOOT   | first cycle out of reset, pc not yet fetchable, inputs ignored
// RUN    | pc valid, next PC selected every cycle
// BUBBLE | one dead fetch slot after trap entry, pc held, inputs ignored
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_JUMP = 3'd2,
        SEL_TRAP = 3'd3,
        SEL_MRET = 3'd4
    } sel_e;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << ALIGN_BITS) - 1);
    localparam bit              HALF_OK    = (ALIGN_BITS < 2);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;

    sel_e            sel;
    logic            trap_is_mis;
    logic            target_mis;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] trap_pc;
    logic            pc_valid;

    assign target_mis = (bus.jump_target & ALIGN_MASK) != '0;
    assign trap_pc    = bus.trap_vector & ~ALIGN_MASK;
    assign step       = (HALF_OK && bus.inc_half) ? XLEN'(2) : XLEN'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    // Request priority: trap > mret > misaligned jump > jump > increment > hold.
    always_comb begin
        state_d     = state_q;
        sel         = SEL_HOLD;
        trap_is_mis = 1'b0;
        case (state_q)
            ST_BOOT, ST_BUBBLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.trap) begin
                    sel     = SEL_TRAP;
                    state_d = ST_BUBBLE;
                end else if (bus.advance && bus.mret) begin
                    sel = SEL_MRET;
                end else if (bus.advance && bus.jump && target_mis) begin
                    sel         = SEL_TRAP;
                    trap_is_mis = 1'b1;
                    state_d     = ST_BUBBLE;
                end else if (bus.advance && bus.jump) begin
                    sel = SEL_JUMP;
                end else if (bus.advance) begin
                    sel = SEL_SEQ;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        mis_d    = mis_q;
        pc_valid = (state_q == ST_RUN);
        case (sel)
            SEL_SEQ:  pc_d = pc_q + step;
            SEL_JUMP: pc_d = bus.jump_target;
            SEL_TRAP: begin
                epc_d = pc_q;
                pc_d  = trap_pc;
                mis_d = trap_is_mis;
            end
            SEL_MRET: begin
                pc_d  = epc_q;
                mis_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.pc_valid   = pc_valid;
    assign bus.epc        = epc_q;
    assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios on a 4-byte-aligned and a 2-byte-aligned
// instance, then randomized traffic against a behavioural next-PC model.
module tb_pc_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_seq_if #(.XLEN(32)) bus2 ();
    pc_seq_if #(.XLEN(32)) bus1 ();

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));
    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    task automatic drive(input logic adv, input logic half, input logic jmp,
                         input logic [31:0] jt, input logic trp,
                         input logic [31:0] tv, input logic mr);
        bus2.advance = adv; bus2.inc_half = half; bus2.jump = jmp; bus2.jump_target = jt;
        bus2.trap = trp; bus2.trap_vector = tv; bus2.mret = mr;
        bus1.advance = adv; bus1.inc_half = half; bus1.jump = jmp; bus1.jump_target = jt;
        bus1.trap = trp; bus1.trap_vector = tv; bus1.mret = mr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rules applied to one model state.
    function automatic void model_next(input int ab, input logic adv, input logic half,
                                       input logic jmp, input logic [31:0] jt,
                                       input logic trp, input logic [31:0] tv, input logic mr,
                                       inout logic [31:0] p, inout logic [31:0] e,
                                       inout logic mis, inout logic v);
        logic [31:0] mask;
        mask = (32'd1 << ab) - 32'd1;
        if (!v) begin
            v = 1'b1;
        end else if (trp) begin
            e = p; p = tv & ~mask; mis = 1'b0; v = 1'b0;
        end else if (adv && mr) begin
            p = e; mis = 1'b0;
        end else if (adv && jmp && ((jt & mask) != 0)) begin
            e = p; p = tv & ~mask; mis = 1'b1; v = 1'b0;
        end else if (adv && jmp) begin
            p = jt;
        end else if (adv) begin
            p = p + ((ab == 1 && half) ? 32'd2 : 32'd4);
        end
    endfunction

    task automatic test_reset();
        idle();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc} !== {2'b00, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_async got valid=%0b mis=%0b epc=%h pc=%h want 0 0 0 0",
                     bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc);
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus2.pc_valid !== 1'b0 || bus1.pc_valid !== 1'b0) begin
            failures++;
            $display("FAIL boot_bubble got valid2=%0b valid1=%0b want 0", bus2.pc_valid, bus1.pc_valid);
        end
        tick();
        checks++;
        if (bus2.pc_valid !== 1'b1 || bus2.pc !== 32'h0) begin
            failures++;
            $display("FAIL boot_to_run got valid=%0b pc=%h want 1 00000000", bus2.pc_valid, bus2.pc);
        end
    endtask

    task automatic test_sequential();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (bus2.pc !== 32'(4 * k) || bus1.pc !== 32'(4 * k)) begin
                failures++;
                $display("FAIL seq_step%0d got pc2=%h pc1=%h want %h", k, bus2.pc, bus1.pc, 32'(4 * k));
            end
        end
        idle();
    endtask

    task automatic test_half_step();
        drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checks++;
        if (bus1.pc !== 32'h102 || bus2.pc !== 32'h104) begin
            failures++;
            $display("FAIL half_step got pc1=%h pc2=%h want 00000102 00000104", bus1.pc, bus2.pc);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checks++;
        if (bus1.pc !== 32'h106 || bus2.pc !== 32'h108) begin
            failures++;
            $display("FAIL full_step got pc1=%h pc2=%h want 00000106 00000108", bus1.pc, bus2.pc);
        end
        idle();
    endtask

    task automatic test_misaligned_jump();
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h202, 1'b0, 32'h80, 1'b0);
        tick();
        checks++;
        if ({bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc} !== {2'b01, 32'h40, 32'h80}) begin
            failures++;
            $display("FAIL mis_trap got valid=%0b mis=%0b epc=%h pc=%h want 0 1 00000040 00000080",
                     bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc);
        end
        checks++;
        if (bus1.pc !== 32'h202 || bus1.misaligned !== 1'b0 || bus1.pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL half_aligned_jump got pc=%h mis=%0b valid=%0b want 00000202 0 1",
                     bus1.pc, bus1.misaligned, bus1.pc_valid);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
        tick();
        checks++;
        if (bus2.pc !== 32'h80 || bus2.pc_valid !== 1'b1 || bus2.misaligned !== 1'b1) begin
            failures++;
            $display("FAIL bubble_ignores got pc=%h valid=%0b mis=%0b want 00000080 1 1",
                     bus2.pc, bus2.pc_valid, bus2.misaligned);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        checks++;
        if (bus2.pc !== 32'h40 || bus2.misaligned !== 1'b0 || bus2.epc !== 32'h40) begin
            failures++;
            $display("FAIL mret got pc=%h mis=%0b epc=%h want 00000040 0 00000040",
                     bus2.pc, bus2.misaligned, bus2.epc);
        end
        idle();
    endtask

    task automatic test_priority();
        drive(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 32'h83, 1'b1);
        tick();
        checks++;
        if ({bus2.pc_valid, bus2.epc, bus2.pc} !== {1'b0, 32'h10, 32'h80} || bus1.pc !== 32'h82) begin
            failures++;
            $display("FAIL trap_wins got valid=%0b epc=%h pc=%h pc1=%h want 0 00000010 00000080 00000082",
                     bus2.pc_valid, bus2.epc, bus2.pc, bus1.pc);
        end
        idle();
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1);
        tick();
        checks++;
        if (bus2.pc !== 32'h10 || bus2.pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL mret_beats_jump got pc=%h valid=%0b want 00000010 1", bus2.pc, bus2.pc_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
        tick();
        checks++;
        if ({bus2.pc_valid, bus2.epc, bus2.pc} !== {1'b0, 32'h10, 32'h20}) begin
            failures++;
            $display("FAIL trap_no_advance got valid=%0b epc=%h pc=%h want 0 00000010 00000020",
                     bus2.pc_valid, bus2.epc, bus2.pc);
        end
        idle();
        tick();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 1'b1, 32'h3, 1'b0, 32'h60, 1'b0);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checks++;
        if ({bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc} !== {2'b11, 32'h20, 32'h0}) begin
            failures++;
            $display("FAIL wrap got valid=%0b mis=%0b epc=%h pc=%h want 1 1 00000020 00000000",
                     bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc);
        end
        idle();
    endtask

    task automatic test_reset_in_bubble();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        tick();
        idle();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc} !== {2'b00, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_in_bubble got valid=%0b mis=%0b epc=%h pc=%h want 0 0 0 0",
                     bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (bus2.pc_valid !== 1'b1 || bus2.pc !== 32'h0) begin
            failures++;
            $display("FAIL reboot got valid=%0b pc=%h want 1 00000000", bus2.pc_valid, bus2.pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] mp [2];
        logic [31:0] me [2];
        logic        mm [2];
        logic        mv [2];
        logic        adv, half, jmp, trp, mr;
        logic [31:0] jt, tv;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mp[i] = 32'h0; me[i] = 32'h0; mm[i] = 1'b0; mv[i] = 1'b0;
        end
        for (int n = 0; n < 600; n++) begin
            adv  = ($urandom_range(0, 3) != 0);
            half = $urandom_range(0, 1) == 1;
            jmp  = ($urandom_range(0, 3) == 0);
            trp  = ($urandom_range(0, 15) == 0);
            mr   = ($urandom_range(0, 7) == 0);
            tv   = $urandom;
            case ($urandom_range(0, 2))
                0:       jt = $urandom & 32'hFFFF_FFFC;
                1:       jt = $urandom;
                default: jt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            drive(adv, half, jmp, jt, trp, tv, mr);
            model_next(2, adv, half, jmp, jt, trp, tv, mr, mp[0], me[0], mm[0], mv[0]);
            model_next(1, adv, half, jmp, jt, trp, tv, mr, mp[1], me[1], mm[1], mv[1]);
            tick();
            checks++;
            if ({bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc} !== {mv[0], mm[0], me[0], mp[0]}) begin
                failures++;
                $display("FAIL rand_a2 cycle %0d got v=%0b m=%0b epc=%h pc=%h want v=%0b m=%0b epc=%h pc=%h",
                         n, bus2.pc_valid, bus2.misaligned, bus2.epc, bus2.pc, mv[0], mm[0], me[0], mp[0]);
            end
            checks++;
            if ({bus1.pc_valid, bus1.misaligned, bus1.epc, bus1.pc} !== {mv[1], mm[1], me[1], mp[1]}) begin
                failures++;
                $display("FAIL rand_a1 cycle %0d got v=%0b m=%0b epc=%h pc=%h want v=%0b m=%0b epc=%h pc=%h",
                         n, bus1.pc_valid, bus1.misaligned, bus1.epc, bus1.pc, mv[1], mm[1], me[1], mp[1]);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_half_step();
        test_misaligned_jump();
        test_priority();
        test_wrap();
        test_reset_in_bubble();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
